// File: rtl/mmu_refill_if.sv
// Table-read bus between the MMU refill walker (master) and the memory port (slave).
// mem_rdata is valid in the cycle mem_ack is high.
interface mmu_refill_if #(
    parameter int RV = 16
);
    logic          mem_req;
    logic [RV-1:0] mem_addr;
    logic          mem_ack;
    logic [RV-1:0] mem_rdata;

    modport master (output mem_req, mem_addr, input mem_ack, mem_rdata);
    modport slave  (input mem_req, mem_addr, output mem_ack, mem_rdata);
endinterface

// File: rtl/mmu_refill.sv
// Hardware page-table walker: on an MMU miss/protect fault, fetch the PTE and write it back.
// Optional MMU_REFILL_TIMEOUT_EN: retry stalled table reads and give up after three timeouts.
module mmu_refill #(
    parameter int RV   = 16,
    parameter int PA   = RV,
    parameter int VA   = RV,
    parameter int NMMU = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          mmu_fault,
    input  logic [RV-1:0] fault_reg,
    output logic          reg_write,
    output logic [RV-1:0] reg_data,
    input  logic          base_write,
    input  logic [RV-1:0] base_data,
    mmu_refill_if.master  mem,
    output logic          busy,
    output logic          done,
    output logic          walk_fault
);
    localparam int U   = VA - $clog2(NMMU);
    localparam int IW  = $clog2(NMMU) + 2;
    localparam int PPW = PA - U;

    typedef enum logic [1:0] {IDLE, CAPTURE, FETCH, WRITE} state_t;

    state_t        state_q, state_d;
    logic [RV-1:0] base_q, base_d;
    logic          type_q, type_d;
    logic [RV-1:0] mem_addr_q, mem_addr_d;
    logic          mem_req_q, mem_req_d;
    logic          reg_write_q, reg_write_d;
    logic [RV-1:0] reg_data_q, reg_data_d;
    logic          done_q, done_d;
    logic          walk_fault_q, walk_fault_d;
    logic          busy_q, busy_d;
`ifdef MMU_REFILL_TIMEOUT_EN
    logic [3:0]    wait_cnt_q, wait_cnt_d;
    logic [1:0]    retry_q, retry_d;
`endif

    logic [IW-1:0] idx;
    logic          pte_bad;
    logic          unused_bits;

    // Table slot: instruction/supervisor space selects one of four page groups.
    assign idx     = {fault_reg[3], fault_reg[2], fault_reg[VA-1:U]};
    assign pte_bad = !mem.mem_rdata[1] || (!type_q && !mem.mem_rdata[2]);
    assign unused_bits = ^{fault_reg[U-1:4], fault_reg[0], mem.mem_rdata[0]};

    always_comb begin
        // NOTE: every _d starts from a default so no branch can leave it unassigned (no latch).
        state_d      = state_q;
        base_d       = base_q;
        type_d       = type_q;
        mem_addr_d   = mem_addr_q;
        mem_req_d    = mem_req_q;
        reg_write_d  = 1'b0;
        reg_data_d   = reg_data_q;
        done_d       = 1'b0;
        walk_fault_d = 1'b0;
`ifdef MMU_REFILL_TIMEOUT_EN
        wait_cnt_d   = wait_cnt_q;
        retry_d      = retry_q;
`endif

        if (base_write) base_d = base_data;

        case (state_q)
            IDLE: if (mmu_fault) state_d = CAPTURE;
            CAPTURE: begin
                type_d     = fault_reg[1];
                mem_addr_d = base_q + RV'({idx, 1'b0});
                mem_req_d  = 1'b1;
                state_d    = FETCH;
`ifdef MMU_REFILL_TIMEOUT_EN
                wait_cnt_d = '0;
                retry_d    = '0;
`endif
            end
            FETCH: begin
                if (mem_req_q && mem.mem_ack) begin
                    mem_req_d = 1'b0;
                    if (pte_bad) begin
                        walk_fault_d = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        reg_write_d = 1'b1;
                        done_d      = 1'b1;
                        reg_data_d  = {mem.mem_rdata[RV-1:RV-PPW], mem.mem_rdata[RV-PPW-1:1], 1'b1};
                        state_d     = WRITE;
                    end
                end
`ifdef MMU_REFILL_TIMEOUT_EN
                else if (!mem_req_q) begin
                    mem_req_d = 1'b1;
                end else if (wait_cnt_q == 4'd14) begin
                    // Fifteenth unanswered cycle: drop the request for one cycle, or give up.
                    wait_cnt_d = '0;
                    mem_req_d  = 1'b0;
                    if (retry_q == 2'd2) begin
                        walk_fault_d = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        retry_d = retry_q + 2'd1;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end
`endif
            end
            WRITE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE) || walk_fault_d;
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
        if (reset) begin
            state_q      <= IDLE;
            base_q       <= '0;
            type_q       <= 1'b0;
            mem_addr_q   <= '0;
            mem_req_q    <= 1'b0;
            reg_write_q  <= 1'b0;
            reg_data_q   <= '0;
            done_q       <= 1'b0;
            walk_fault_q <= 1'b0;
            busy_q       <= 1'b0;
`ifdef MMU_REFILL_TIMEOUT_EN
            wait_cnt_q   <= '0;
            retry_q      <= '0;
`endif
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            type_q       <= type_d;
            mem_addr_q   <= mem_addr_d;
            mem_req_q    <= mem_req_d;
            reg_write_q  <= reg_write_d;
            reg_data_q   <= reg_data_d;
            done_q       <= done_d;
            walk_fault_q <= walk_fault_d;
            busy_q       <= busy_d;
`ifdef MMU_REFILL_TIMEOUT_EN
            wait_cnt_q   <= wait_cnt_d;
            retry_q      <= retry_d;
`endif
        end
    end

    assign mem.mem_req  = mem_req_q;
    assign mem.mem_addr = mem_addr_q;
    assign reg_write    = reg_write_q;
    assign reg_data     = reg_data_q;
    assign done         = done_q;
    assign walk_fault   = walk_fault_q;
    assign busy         = busy_q;
endmodule

// File: tb/tb_mmu_refill.sv
// Directed bench for mmu_refill (RV=16, NMMU=8): refills, PTE faults, wrap-around, reset abort,
// and the unanswered-read behaviour of whichever build (MMU_REFILL_TIMEOUT_EN or not) is compiled.
module tb_mmu_refill;
    logic        clk = 1'b0;
    logic        reset;
    logic        mmu_fault;
    logic [15:0] fault_reg;
    logic        reg_write;
    logic [15:0] reg_data;
    logic        base_write;
    logic [15:0] base_data;
    logic        busy, done, walk_fault;

    int checks   = 0;
    int failures = 0;
    int rw_count = 0;

    mmu_refill_if #(.RV(16)) mem_if ();

    mmu_refill #(.RV(16), .NMMU(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .mmu_fault  (mmu_fault),
        .fault_reg  (fault_reg),
        .reg_write  (reg_write),
        .reg_data   (reg_data),
        .base_write (base_write),
        .base_data  (base_data),
        .mem        (mem_if),
        .busy       (busy),
        .done       (done),
        .walk_fault (walk_fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Strobes never overlap, and every write pulse is counted for the abort checks.
    always @(negedge clk) begin
        if (!reset) begin
            checks++;
            assert (!(walk_fault && (reg_write || done))) else begin
                failures++;
                $error("FAIL exclusive_pulses observed=%b%b%b expected=no walk_fault with write",
                       reg_write, done, walk_fault);
            end
            if (reg_write) rw_count++;
        end
    end

    task automatic load_base(input logic [15:0] b);
        base_write = 1'b1;
        base_data  = b;
        step();
        base_write = 1'b0;
    endtask

    // Present a fault for one cycle; returns in the CAPTURE cycle.
    task automatic fault_in(input string tag, input logic [15:0] fr);
        mmu_fault = 1'b1;
        fault_reg = fr;
        step();
        mmu_fault = 1'b0;
        check({tag, "_capture_busy"}, busy, 1);
        check({tag, "_capture_noreq"}, mem_if.mem_req, 0);
    endtask

    task automatic walk(input string tag, input logic [15:0] fr, input logic [15:0] pte,
                        input int waits, input logic [15:0] exp_addr, input bit exp_ok,
                        input bit disturb);
        fault_in(tag, fr);
        step();
        check({tag, "_req"}, mem_if.mem_req, 1);
        check({tag, "_addr"}, mem_if.mem_addr, exp_addr);
        for (int i = 0; i < waits; i++) begin
            if (disturb && i == 0) begin
                mmu_fault  = 1'b1;
                fault_reg  = 16'h0002;
                base_write = 1'b1;
                base_data  = 16'h1000;
            end
            step();
            mmu_fault  = 1'b0;
            base_write = 1'b0;
            check({tag, "_wait_req"}, mem_if.mem_req, 1);
            check({tag, "_wait_addr"}, mem_if.mem_addr, exp_addr);
        end
        mem_if.mem_ack   = 1'b1;
        mem_if.mem_rdata = pte;
        step();
        mem_if.mem_ack   = 1'b0;
        mem_if.mem_rdata = 16'hDEAD;
        check({tag, "_reg_write"}, reg_write, exp_ok);
        check({tag, "_done"}, done, exp_ok);
        check({tag, "_walk_fault"}, walk_fault, !exp_ok);
        check({tag, "_busy"}, busy, 1);
        check({tag, "_req_drop"}, mem_if.mem_req, 0);
        if (exp_ok) check({tag, "_reg_data"}, reg_data, pte | 16'h0001);
        step();
        check({tag, "_idle_busy"}, busy, 0);
        check({tag, "_idle_pulses"}, {reg_write, done, walk_fault}, 3'b000);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        int rw_saved;
        reset            = 1'b1;
        mmu_fault        = 1'b0;
        fault_reg        = 16'h0000;
        base_write       = 1'b0;
        base_data        = 16'h0000;
        mem_if.mem_ack   = 1'b0;
        mem_if.mem_rdata = 16'h0000;
        step();
        step();
        check("rst_outputs", {mem_if.mem_req, reg_write, done, walk_fault, busy}, 5'b0);
        check("rst_reg_data", reg_data, 16'h0000);
        check("rst_mem_addr", mem_if.mem_addr, 16'h0000);
        reset = 1'b0;
        step();

        // Miss in ins/user page 5: slot 21, byte offset 0x2A.
        load_base(16'h4000);
        walk("miss_ok", 16'hA00A, 16'h6002, 0, 16'h402A, 1'b1, 1'b0);
        walk("miss_invalid", 16'hA00A, 16'h6000, 2, 16'h402A, 1'b0, 1'b0);
        // Write-protect fault in data/sup page 1: slot 9, offset 0x12.
        walk("wp_readonly", 16'h2004, 16'h8002, 0, 16'h4012, 1'b0, 1'b0);
        walk("wp_writeable", 16'h2004, 16'h8006, 1, 16'h4012, 1'b1, 1'b0);

        // Slot 31 past 0xFFF0 wraps; a second fault and a base load arrive mid-fetch.
        load_base(16'hFFF0);
        walk("wrap", 16'hE00C, 16'h8006, 2, 16'h002E, 1'b1, 1'b1);
        walk("new_base", 16'hA00A, 16'h6002, 0, 16'h102A, 1'b1, 1'b0);

        // Reset in FETCH with an ack pending aborts the walk and clears the base.
        rw_saved = rw_count;
        fault_in("abort", 16'hA00A);
        step();
        check("abort_fetch_req", mem_if.mem_req, 1);
        reset            = 1'b1;
        mem_if.mem_ack   = 1'b1;
        mem_if.mem_rdata = 16'h6002;
        step();
        mem_if.mem_ack = 1'b0;
        reset          = 1'b0;
        check("abort_outputs", {mem_if.mem_req, busy, reg_write, done}, 4'b0);
        check("abort_reg_data", reg_data, 16'h0000);
        check("abort_mem_addr", mem_if.mem_addr, 16'h0000);
        step();
        step();
        check("abort_no_write", rw_count, rw_saved);
        check("abort_idle", busy, 0);
        walk("zero_base", 16'hA00A, 16'h6002, 0, 16'h002A, 1'b1, 1'b0);

        rw_saved = rw_count;
        fault_in("noack", 16'hA00A);
`ifdef MMU_REFILL_TIMEOUT_EN
        begin
            int  bursts = 0;
            int  run    = 0;
            bit  prev   = 1'b0;
            bit  wf     = 1'b0;
            int  lens[4] = '{0, 0, 0, 0};
            for (int i = 0; i < 80 && !wf; i++) begin
                step();
                if (mem_if.mem_req) begin
                    if (!prev) bursts++;
                    run++;
                end else if (prev) begin
                    if (bursts >= 1 && bursts <= 4) lens[bursts-1] = run;
                    run = 0;
                end
                prev = mem_if.mem_req;
                wf   = walk_fault;
            end
            check("timeout_walk_fault", wf, 1);
            check("timeout_bursts", bursts, 3);
            check("timeout_len0", lens[0], 15);
            check("timeout_len1", lens[1], 15);
            check("timeout_len2", lens[2], 15);
            check("timeout_busy", busy, 1);
            step();
            check("timeout_idle", busy, 0);
            check("timeout_no_write", rw_count, rw_saved);
        end
`else
        begin
            bit held = 1'b1;
            step();
            for (int i = 0; i < 100; i++) begin
                step();
                if (mem_if.mem_req !== 1'b1 || mem_if.mem_addr !== 16'h002A || busy !== 1'b1)
                    held = 1'b0;
            end
            check("noack_held_100", held, 1);
            check("noack_no_write", rw_count, rw_saved);
            mem_if.mem_ack   = 1'b1;
            mem_if.mem_rdata = 16'h6002;
            step();
            mem_if.mem_ack = 1'b0;
            check("noack_late_write", reg_write, 1);
            check("noack_late_data", reg_data, 16'h6003);
            step();
            check("noack_idle", busy, 0);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mmu_refill.md
MMU_REFILL -- requirements
Module: mmu_refill

Interface
REQ-001 SHALL have parameter RV, default 16, meaning datapath, register and memory word width.
REQ-002 SHALL have parameter PA, default RV, meaning physical address width.
REQ-003 SHALL have parameter VA, default RV, meaning virtual address width.
REQ-004 SHALL have parameter NMMU, default 8, meaning MMU pages per space; U = VA-$clog2(NMMU); index width IW = $clog2(NMMU)+2.
REQ-005 SHALL have port clk  in  1  clock.
REQ-006 SHALL have port reset  in  1  reset, synchronous, active-high.
REQ-007 SHALL have port mmu_fault  in  1  MMU fault strobe; MMU fault register updates on the same edge.
REQ-008 SHALL have port fault_reg  in  RV  MMU register read value: [VA-1:U] page, [3] ins, [2] sup, [1] type (1 = miss, 0 = write-protect).
REQ-009 SHALL have port reg_write  out  1  MMU register write strobe.
REQ-010 SHALL have port reg_data  out  RV  MMU register write data.
REQ-011 SHALL have port base_write  in  1  load page-table base.
REQ-012 SHALL have port base_data  in  RV  page-table base byte address.
REQ-013 SHALL have port mem_req  out  1  table read request.
REQ-014 SHALL have port mem_addr  out  RV  table read byte address.
REQ-015 SHALL have port mem_ack  in  1  read complete; mem_rdata valid in this cycle.
REQ-016 SHALL have port mem_rdata  in  RV  PTE: [RV-1:RV-(PA-U)] phys page, [2] writeable, [1] valid, [0] ignored.
REQ-017 SHALL have port busy  out  1  walk in progress (CPU stall).
REQ-018 SHALL have port done  out  1  one-cycle pulse: entry written.
REQ-019 SHALL have port walk_fault  out  1  one-cycle pulse: escalate to software trap.

Function
REQ-020 SHALL implement states IDLE, CAPTURE, FETCH, WRITE.
REQ-021 SHALL go IDLE->CAPTURE on a clock edge where mmu_fault=1; mmu_fault outside IDLE SHALL be ignored.
REQ-022 In CAPTURE, SHALL latch idx = {fault_reg[3], fault_reg[2], fault_reg[VA-1:U]} and type = fault_reg[1]; SHALL latch mem_addr = base + {idx,1'b0} (mod 2^RV); next state FETCH.
REQ-023 In FETCH, SHALL hold mem_req=1 with mem_addr stable until an edge with mem_ack=1, then capture mem_rdata.
REQ-024 If PTE[1]=0, or type=0 with PTE[2]=0, SHALL pulse walk_fault in the following cycle, perform no register write, and return to IDLE.
REQ-025 Otherwise SHALL enter WRITE: reg_write=1 for exactly one cycle with reg_data = {PTE[RV-1:1], 1'b1}; done=1 in the same cycle; then IDLE.
REQ-026 busy SHALL be 1 in CAPTURE, FETCH, WRITE and in the walk_fault cycle, and 0 otherwise.
REQ-027 Fault-to-write latency with a zero-wait ack SHALL be 4 cycles: fault edge, CAPTURE, FETCH(ack), WRITE.
REQ-028 base_write SHALL update base in any state; a walk past CAPTURE SHALL use the previously latched mem_addr.
REQ-029 reg_write, done and walk_fault SHALL never be asserted together.

Reset
REQ-030 On reset, state SHALL be IDLE; base SHALL be 0; mem_req, reg_write, done, walk_fault and busy SHALL be 0; and reg_data and mem_addr SHALL be 0.
REQ-031 Reset during a walk SHALL abort it with no reg_write and no done.

Configuration
REQ-032 Macro MMU_REFILL_TIMEOUT_EN defined: SHALL maintain a 4-bit wait counter in FETCH; after 15 cycles without ack it SHALL drop mem_req for one cycle and re-request, and on a third timeout SHALL pulse walk_fault and return to IDLE.
REQ-033 Macro MMU_REFILL_TIMEOUT_EN undefined: FETCH SHALL wait for mem_ack indefinitely, with no counter logic.

Verification (RV=16, NMMU=8, U=13)
REQ-034 Scenario: base 0x4000, fault_reg=0xA00A, PTE 0x6002, ack after 0 waits -> mem_addr=0x402A; reg_write with reg_data=0x6003; done 4 cycles after the fault edge.
REQ-035 Scenario: same fault, PTE 0x6000 -> walk_fault pulse; no reg_write.
REQ-036 Scenario: fault_reg=0x2004 (type=0), PTE 0x8002 -> walk_fault; PTE 0x8006 -> reg_data=0x8007.
REQ-037 Scenario: base 0xFFF0, fault_reg=0xE00C -> mem_addr=0x002E (wrap-around); second mmu_fault during FETCH is ignored.
REQ-038 Scenario: reset asserted during FETCH -> mem_req=0 and busy=0 next cycle; no reg_write.
REQ-039 Scenario (TIMEOUT_EN): mem_ack never asserted -> three request bursts, then walk_fault; without the macro, mem_req stays high for 100 cycles.
